// File: rtl/vga_frame_capture.sv
// Crops a window out of a registered VGA stream and writes it column-major through a small FIFO.
// Optional macro LUMA_EN stores (r + 2g + b) / 4 instead of green, adding one pipeline stage.
module vga_frame_capture #(
  parameter int WIN_X0     = 0,
  parameter int WIN_Y0     = 0,
  parameter int WIN_W      = 300,
  parameter int WIN_H      = 300,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [7:0]        vid_r,
  input  logic [7:0]        vid_g,
  input  logic [7:0]        vid_b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);
  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic signed [13:0] X0_S = 14'(WIN_X0);
  localparam logic signed [13:0] Y0_S = 14'(WIN_Y0);
  localparam logic signed [13:0] W_S  = 14'(WIN_W);
  localparam logic signed [13:0] H_S  = 14'(WIN_H);
  localparam logic [11:0] Y_LAST = 12'(WIN_Y0 + WIN_H - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

`ifdef LUMA_EN
  function automatic logic [DATA_W-1:0] luma(input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
  endfunction
`endif

  // Stage p0: registered video inputs and edge detection
  logic              hs_p0, vs_p0, de_p0, vs_prev, de_prev;
  logic [7:0]        r_p0, g_p0, b_p0;
  logic              unused_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_p0   <= 1'b0;
      vs_p0   <= 1'b0;
      de_p0   <= 1'b0;
      vs_prev <= 1'b0;
      de_prev <= 1'b0;
    end else begin
      hs_p0   <= vid_hs;
      vs_p0   <= vid_vs;
      de_p0   <= vid_de;
      vs_prev <= vs_p0;
      de_prev <= de_p0;
    end
  end

  always_ff @(posedge clk) begin
    r_p0 <= vid_r;
    g_p0 <= vid_g;
    b_p0 <= vid_b;
  end

`ifdef LUMA_EN
  assign unused_in = hs_p0;
`else
  assign unused_in = ^{hs_p0, r_p0, b_p0};
`endif

  logic vs_fall, de_fall, cap_end;
  assign vs_fall = vs_prev & ~vs_p0;
  assign de_fall = de_prev & ~de_p0;

  logic [11:0] col, row;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= de_p0 ? sat_inc(col) : '0;
      if (vs_fall)      row <= '0;
      else if (de_fall) row <= sat_inc(row);
    end
  end

  logic signed [13:0] col_off, row_off;
  logic               hit;
  logic [31:0]        addr_full;
  assign col_off   = $signed({2'b00, col}) - X0_S;
  assign row_off   = $signed({2'b00, row}) - Y0_S;
  assign hit       = de_p0 && (col_off >= 14'sd0) && (col_off < W_S)
                            && (row_off >= 14'sd0) && (row_off < H_S);
  assign addr_full = 32'(col_off[12:0]) * 32'(WIN_H) + 32'(row_off[12:0]);
  assign cap_end   = de_fall && (row == Y_LAST);

  // Stage p1: window pixel with its column-major address
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] pix_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= hit && (state == ST_CAPTURE);
  end

  always_ff @(posedge clk) begin
    addr_p1 <= ADDR_W'(addr_full);
`ifdef LUMA_EN
    pix_p1  <= luma(r_p0, g_p0, b_p0);
`else
    pix_p1  <= g_p0;
`endif
  end

  logic              push_vld, pipe_busy;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_pix;

`ifdef LUMA_EN
  // Stage p2: extra register for the luma path
  logic              vld_p2;
  logic [ADDR_W-1:0] addr_p2;
  logic [DATA_W-1:0] pix_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p2 <= 1'b0;
    else          vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    addr_p2 <= addr_p1;
    pix_p2  <= pix_p1;
  end

  assign push_vld  = vld_p2;
  assign push_addr = addr_p2;
  assign push_pix  = pix_p2;
  assign pipe_busy = vld_p1 | vld_p2;
`else
  assign push_vld  = vld_p1;
  assign push_addr = addr_p1;
  assign push_pix  = pix_p1;
  assign pipe_busy = vld_p1;
`endif

  // Pixel FIFO; a full FIFO still accepts a push when the head leaves in the same cycle
  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]           wr_ptr, rd_ptr;
  logic                     empty, full, pop, push, drop;
  logic [ADDR_W+DATA_W-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && mem_ready;
  assign push  = push_vld && (!full || pop);
  assign drop  = push_vld && !push;
  assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {push_addr, push_pix};
  end

  assign mem_we   = !empty;
  assign mem_addr = empty ? '0 : head[ADDR_W+DATA_W-1:DATA_W];
  assign mem_data = empty ? '0 : head[DATA_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    unique case (state)
      ST_IDLE:    if (start) state_nxt = ST_ARM;
      ST_ARM:     if (vs_fall) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (vs_fall || cap_end) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (empty && !pipe_busy) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= 2'b00;
    end else if (state == ST_IDLE && start) begin
      status <= 2'b00;
    end else begin
      if (drop) status[0] <= 1'b1;
      if (state == ST_CAPTURE && vs_fall && !cap_end) status[1] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vga_frame_capture.sv
// Scoreboard bench: frame driver queues expected column-major writes, a monitor checks them.
module tb_vga_frame_capture;
  localparam int X0 = 2, Y0 = 1, W = 4, H = 3, AW = 18, FD = 4;
  localparam int ACT = 8, HB = 4;
`ifdef LUMA_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          reset_n, start, vid_hs, vid_vs, vid_de, mem_ready;
  logic [7:0]    vid_r, vid_g, vid_b, mem_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we, busy, done;
  logic [1:0]    status;

  vga_frame_capture #(.WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H),
                      .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .vid_de(vid_de), .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .busy(busy), .done(done), .status(status));

  always #5 clk = ~clk;

  typedef struct {logic [AW-1:0] addr; logic [7:0] data;} exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, done_cnt = 0, nwrites = 0, drops = 0;
  int ready_mode = 0, stall_cnt = 0, lat_k = 0, lat_seen = 0;
  bit allow_drop = 0, lat_armed = 0, we_seen = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr;
  logic [7:0]    prev_data;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] model_pix(input int r, input int g, input int b);
`ifdef LUMA_EN
    return 8'((r + 2 * g + b) / 4);
`else
    return 8'(g);
`endif
  endfunction

  // Monitor: samples mid-cycle, a write transfers at the next rising edge
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        checks++;
        if (!mem_we || mem_addr != prev_addr || mem_data != prev_data) begin
          errors++;
          $display("FAIL stall_stable: got we=%0b addr=%0d data=%02h, need we=1 addr=%0d data=%02h",
                   mem_we, mem_addr, mem_data, prev_addr, prev_data);
        end
      end
      if (mem_we && !we_seen) begin
        we_seen  = 1;
        lat_seen = cyc;
      end
      if (mem_we && mem_ready) begin
        nwrites++;
        if (allow_drop)
          while (exp_q.size() > 0 && exp_q[0].addr != mem_addr) begin
            void'(exp_q.pop_front());
            drops++;
          end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0d data=%02h, need no write", mem_addr, mem_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.addr != mem_addr || e.data != mem_data) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%02h, need addr=%0d data=%02h",
                     mem_addr, mem_data, e.addr, e.data);
          end
        end
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h", name, got, need);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: if (stall_cnt > 0) begin mem_ready = 1'b0; stall_cnt--; end
         else mem_ready = 1'b1;
      2: mem_ready = ~mem_ready;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic begin_test();
    done_cnt = 0; nwrites = 0; drops = 0; we_seen = 0;
    exp_q.delete();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_frame(input int n_lines, input bit capt, input int abort_line,
                             input bit stall, input bit mid_start, input bit ramp);
    vid_de = 1'b0; vid_hs = 1'b1;
    vid_vs = 1'b0; repeat (3) tick();
    vid_vs = 1'b1; repeat (3) tick();
    for (int l = 0; l < n_lines; l++) begin
      for (int c = 0; c < ACT; c++) begin
        if (l == abort_line && c == 3) begin
          reset_n = 1'b0;
          exp_q.delete();
          vid_de = 1'b0;
          return;
        end
        vid_de = 1'b1;
        vid_r  = 8'($urandom);
        vid_g  = ramp ? 8'(c + 16 * l) : 8'($urandom);
        vid_b  = 8'($urandom);
        if (capt && c >= X0 && c < X0 + W && l >= Y0 && l < Y0 + H) begin
          exp_q.push_back('{addr: AW'((c - X0) * H + (l - Y0)),
                            data: model_pix(vid_r, vid_g, vid_b)});
          if (lat_armed) begin lat_armed = 0; lat_k = cyc + 1; end
          if (stall && l == Y0 && c == X0) stall_cnt = 20;
        end
        start = (mid_start && l == 1 && c == 0);
        tick();
      end
      start = 1'b0; vid_de = 1'b0;
      for (int h = 0; h < HB; h++) begin
        vid_hs = !(h == 1 || h == 2);
        tick();
      end
    end
    vid_hs = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin tick(); n++; end
    repeat (6) tick();
    chk({name, "_done_count"}, done_cnt, 1);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0;
    vid_r = 8'h0; vid_g = 8'h0; vid_b = 8'h0; mem_ready = 1'b1;
    repeat (3) tick();
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Clean frame, second start during capture must be ignored
    begin_test(); allow_drop = 0; lat_armed = 1;
    do_start();
    chk("t1_busy_armed", busy, 1);
    drive_frame(5, 1, -1, 0, 1, 1);
    wait_done("t1");
    chk("t1_status", status, 2'b00);
    chk("t1_writes", nwrites, 12);
    chk("t1_left", exp_q.size(), 0);
    chk("t1_latency", lat_seen - lat_k, LAT);

    // Backpressure long enough to overflow the FIFO
    begin_test(); ready_mode = 1; allow_drop = 1;
    do_start();
    drive_frame(5, 1, -1, 1, 0, 0);
    wait_done("t2");
    drops += exp_q.size(); exp_q.delete();
    chk("t2_status", status, 2'b01);
    chk("t2_dropped", drops > 0, 1);
    chk("t2_writes_lt12", nwrites < 12, 1);

    // Alternating ready: no drops
    begin_test(); ready_mode = 2; allow_drop = 0;
    do_start();
    chk("t3_status_cleared", status, 2'b00);
    drive_frame(5, 1, -1, 0, 0, 0);
    wait_done("t3");
    chk("t3_status", status, 2'b00);
    chk("t3_writes", nwrites, 12);
    chk("t3_left", exp_q.size(), 0);

    // Short frame: vs returns after two window lines
    begin_test(); ready_mode = 0; allow_drop = 0;
    do_start();
    drive_frame(3, 1, -1, 0, 0, 0);
    drive_frame(1, 0, -1, 0, 0, 0);
    wait_done("t4");
    chk("t4_status", status, 2'b10);
    chk("t4_writes", nwrites, 2 * W);
    chk("t4_left", exp_q.size(), 0);

    // Reset mid-line, then an unarmed frame, then a normal capture
    begin_test();
    do_start();
    drive_frame(5, 1, 2, 0, 0, 0);
    #1;
    chk("t5_rst_we", mem_we, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_data", mem_data, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_status", status, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    nwrites = 0;
    drive_frame(5, 0, -1, 0, 0, 0);
    chk("t5_no_writes", nwrites, 0);
    chk("t5_idle", busy, 0);
    begin_test();
    do_start();
    drive_frame(5, 1, -1, 0, 0, 0);
    wait_done("t5");
    chk("t5_status", status, 2'b00);
    chk("t5_writes", nwrites, 12);

    // Random ready, random pixels
    for (int i = 0; i < 3; i++) begin
      begin_test(); ready_mode = 3; allow_drop = 1;
      do_start();
      drive_frame(5, 1, -1, 0, 0, 0);
      wait_done("t6");
      drops += exp_q.size(); exp_q.delete();
      chk("t6_status", status, {1'b0, drops > 0});
      chk("t6_writes", nwrites, 12 - drops);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
